uart_tx_cfg: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8N1 `uart_tx`. It serialises one word per valid/ready handshake onto `txd` with a configurable data width and stop-bit count. An optional parity bit is available. Bit timing comes from an internal baud divider, so no external `bps_clk_up` strobe is needed. It sits between the host-side data source and the pad, and back-to-back frames leave no idle gap.

---
 rtl/uart_tx_cfg_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 45 ++++
 rtl/uart_tx_cfg.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_cfg_pkg.sv
// uart_tx_cfg_pkg: FSM state encoding and constants for the uart_tx_cfg transmitter.
// The parity encodings and the default divider are also used by uart_rx.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_tx_cfg_pkg;

  localparam int unsigned DefaultClkDiv = 32;

  // Parity polarity selectors for PARITY_ODD.
  localparam int unsigned ParityEven = 0;
  localparam int unsigned ParityOdd  = 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: per-bit cycle counter for the UART transmitter.
// Counts 0..CLK_DIV-1 while run is high, holds at 0 otherwise, and restarts on clear.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       run,
  output logic [$clog2(CLK_DIV)-1:0] bit_cnt,
  output logic                       bit_end
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cnt_last;

  assign cnt_last = (cnt_q == CntW'(CLK_DIV - 1));

  // Next count: clear wins, idle holds at zero, otherwise wrap at the bit end.
  always_comb begin
    cnt_d = '0;
    if (clear || !run) begin
      cnt_d = '0;
    end else if (cnt_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_cnt = cnt_q;
  assign bit_end = run && cnt_last;

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter (DATA_BITS data, STOP_BITS stop, CLK_DIV clocks/bit).
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit (polarity PARITY_ODD).
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned CLK_DIV    = DefaultClkDiv,
  parameter int unsigned PARITY_ODD = ParityEven
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_idle,
  output logic                 tx_bits_ok
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      CLK_DIV < 2 || PARITY_ODD > ParityOdd) begin : gen_cfg_check
    $error("uart_tx_cfg: illegal parameter value");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  // Counts data bits in DATA and stop bits in STOP.
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 txd_q, txd_d;
  logic [CntW-1:0]      bit_cnt;
  logic                 bit_end;
  logic                 accept;
  logic                 last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .run     (state_q != StIdle),
    .bit_cnt (bit_cnt),
    .bit_end (bit_end)
  );

  // Final cycle of the final stop bit: frame done, next word may be taken.
  assign last_stop = (state_q == StStop) && (bit_cnt == CntW'(CLK_DIV - 1)) &&
                     (idx_q == IdxW'(STOP_BITS - 1));
  assign tx_ready   = (state_q == StIdle) || last_stop;
  assign accept     = tx_valid && tx_ready;
  assign tx_bits_ok = last_stop;
  assign tx_idle    = (state_q == StIdle);
  assign txd        = txd_q;

  // Next-state logic: load on acceptance, otherwise advance on each bit end.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      state_d  = StStart;
      shift_d  = tx_data_i;
      idx_d    = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = (^tx_data_i) ^ (PARITY_ODD == ParityOdd);
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StStart: begin
          if (bit_end) begin
            state_d = StData;
            idx_d   = '0;
          end
        end
        StData: begin
          if (bit_end) begin
            shift_d = shift_q >> 1;
            if (idx_q == IdxW'(DATA_BITS - 1)) begin
              idx_d   = '0;
`ifdef UART_TX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            state_d = StStop;
            idx_d   = '0;
          end
        end
`endif
        StStop: begin
          if (bit_end) begin
            if (idx_q == IdxW'(STOP_BITS - 1)) begin
              state_d = StIdle;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Line level for the upcoming state, so txd is registered and aligned with state_q.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      StIdle:   txd_d = 1'b1;
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: txd_d = parity_d;
`endif
      StStop:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  // State, datapath and line registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      idx_q    <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed self-checking bench for uart_tx_cfg (CLK_DIV = 32).
module tb_uart_tx_cfg;

  localparam int unsigned Div = 32;
`ifdef UART_TX_PARITY_EN
  localparam int PBit = 1;
`else
  localparam int PBit = 0;
`endif
  localparam int Nb8 = 10 + PBit;
  localparam int Nb7 = 10 + PBit;

  logic sys_clk = 1'b0;
  logic rst_n;
  always #5 sys_clk = ~sys_clk;

  logic       valid8, rdy8, txd8, idle8, ok8;
  logic [7:0] data8;
  logic       valid7, rdy7, txd7, idle7, ok7;
  logic [6:0] data7;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_cfg #(
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .CLK_DIV    (Div),
    .PARITY_ODD (0)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .tx_valid   (valid8),
    .tx_data_i  (data8),
    .tx_ready   (rdy8),
    .txd        (txd8),
    .tx_idle    (idle8),
    .tx_bits_ok (ok8)
  );

  uart_tx_cfg #(
    .DATA_BITS  (7),
    .STOP_BITS  (2),
    .CLK_DIV    (Div),
    .PARITY_ODD (0)
  ) dut7 (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .tx_valid   (valid7),
    .tx_data_i  (data7),
    .tx_ready   (rdy7),
    .txd        (txd7),
    .tx_idle    (idle7),
    .tx_bits_ok (ok7)
  );

`ifdef UART_TX_PARITY_EN
  logic       valid_o, rdy_o, txd_o, idle_o, ok_o;
  logic [7:0] data_o;

  uart_tx_cfg #(
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .CLK_DIV    (Div),
    .PARITY_ODD (1)
  ) dut_odd (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .tx_valid   (valid_o),
    .tx_data_i  (data_o),
    .tx_ready   (rdy_o),
    .txd        (txd_o),
    .tx_idle    (idle_o),
    .tx_bits_ok (ok_o)
  );
`endif

  // Frame bits, first-sent in bit 0: start, data LSB first, [parity], stop(s).
`ifdef UART_TX_PARITY_EN
  function automatic logic [11:0] frame8(input logic [7:0] d, input logic par);
    return {1'b0, 1'b1, par, d, 1'b0};
  endfunction
  function automatic logic [11:0] frame7(input logic [6:0] d, input logic par);
    return {1'b0, 2'b11, par, d, 1'b0};
  endfunction
`else
  function automatic logic [11:0] frame8(input logic [7:0] d);
    return {2'b00, 1'b1, d, 1'b0};
  endfunction
  function automatic logic [11:0] frame7(input logic [6:0] d);
    return {2'b00, 2'b11, d, 1'b0};
  endfunction
`endif

  // {txd, tx_bits_ok, tx_ready, tx_idle} of the selected instance.
  function automatic logic [3:0] probe(input int sel);
    case (sel)
      1: return {txd7, ok7, rdy7, idle7};
`ifdef UART_TX_PARITY_EN
      2: return {txd_o, ok_o, rdy_o, idle_o};
`endif
      default: return {txd8, ok8, rdy8, idle8};
    endcase
  endfunction

  // Entered at the negedge of the first frame cycle; returns at the negedge of its last cycle.
  task automatic check_frame(input int sel, input logic [11:0] exp_bits, input int nbits,
                             input string name);
    int         bad, bad_ok, bad_rdy, bad_idle;
    int         at_ok, at_rdy, at_idle;
    logic [3:0] s;
    logic       got, last;
    bad_ok = 0; bad_rdy = 0; bad_idle = 0;
    at_ok = 0; at_rdy = 0; at_idle = 0;
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      got = 1'bx;
      for (int c = 0; c < int'(Div); c++) begin
        last = (b == nbits - 1) && (c == int'(Div) - 1);
        s = probe(sel);
        if (s[3] !== exp_bits[b]) begin
          if (bad == 0) got = s[3];
          bad++;
        end
        if (s[2] !== last) begin
          if (bad_ok == 0) at_ok = b * int'(Div) + c + 1;
          bad_ok++;
        end
        if (s[1] !== last) begin
          if (bad_rdy == 0) at_rdy = b * int'(Div) + c + 1;
          bad_rdy++;
        end
        if (s[0] !== 1'b0) begin
          if (bad_idle == 0) at_idle = b * int'(Div) + c + 1;
          bad_idle++;
        end
        if (!last) @(negedge sys_clk);
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s bit %0d: txd got %b in %0d of %0d cycles, required %b",
                 name, b, got, bad, Div, exp_bits[b]);
      end
    end
    n_tests++;
    if (bad_ok != 0) begin
      n_fail++;
      $display("FAIL %s tx_bits_ok: wrong in %0d cycles (first at cycle %0d), required one pulse at cycle %0d",
               name, bad_ok, at_ok, nbits * int'(Div));
    end
    n_tests++;
    if (bad_rdy != 0) begin
      n_fail++;
      $display("FAIL %s tx_ready: wrong in %0d cycles (first at cycle %0d), required high only at cycle %0d",
               name, bad_rdy, at_rdy, nbits * int'(Div));
    end
    n_tests++;
    if (bad_idle != 0) begin
      n_fail++;
      $display("FAIL %s tx_idle: got 1 in %0d cycles (first at cycle %0d), required 0", name,
               bad_idle, at_idle);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid8 = 1'b0; data8 = '0;
    valid7 = 1'b0; data7 = '0;
`ifdef UART_TX_PARITY_EN
    valid_o = 1'b0; data_o = '0;
`endif
    @(negedge sys_clk);
    n_tests++; if (txd8 !== 1'b1) begin n_fail++; $display("FAIL reset txd: got %b required 1", txd8); end
    n_tests++; if (idle8 !== 1'b1) begin n_fail++; $display("FAIL reset tx_idle: got %b required 1", idle8); end
    n_tests++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL reset tx_ready: got %b required 1", rdy8); end
    n_tests++; if (ok8 !== 1'b0) begin n_fail++; $display("FAIL reset tx_bits_ok: got %b required 0", ok8); end
    n_tests++; if (txd7 !== 1'b1) begin n_fail++; $display("FAIL reset txd7: got %b required 1", txd7); end
    rst_n = 1'b1;
    @(negedge sys_clk);
    n_tests++; if (txd8 !== 1'b1) begin n_fail++; $display("FAIL post-reset txd: got %b required 1", txd8); end
    n_tests++; if (idle8 !== 1'b1) begin n_fail++; $display("FAIL post-reset tx_idle: got %b required 1", idle8); end
    n_tests++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL post-reset tx_ready: got %b required 1", rdy8); end
    n_tests++; if (ok8 !== 1'b0) begin n_fail++; $display("FAIL post-reset tx_bits_ok: got %b required 0", ok8); end
  endtask

  task automatic test_single_frame();
    valid8 = 1'b1;
    data8  = 8'h6E;
    @(negedge sys_clk);
    valid8 = 1'b0;
    data8  = 8'h91;  // must not disturb the captured word
`ifdef UART_TX_PARITY_EN
    check_frame(0, frame8(8'h6E, 1'b1), Nb8, "single_6e");
`else
    check_frame(0, frame8(8'h6E), Nb8, "single_6e");
`endif
    @(negedge sys_clk);
    n_tests++; if (idle8 !== 1'b1) begin n_fail++; $display("FAIL single_6e idle after: got %b required 1", idle8); end
    n_tests++; if (txd8 !== 1'b1) begin n_fail++; $display("FAIL single_6e txd after: got %b required 1", txd8); end
    n_tests++; if (ok8 !== 1'b0) begin n_fail++; $display("FAIL single_6e tx_bits_ok after: got %b required 0", ok8); end
  endtask

  task automatic test_back_to_back();
    valid8 = 1'b1;
    data8  = 8'hF0;
    @(negedge sys_clk);
    data8 = 8'h0F;  // offered while busy, taken only at the frame end
`ifdef UART_TX_PARITY_EN
    check_frame(0, frame8(8'hF0, 1'b0), Nb8, "b2b_f0");
`else
    check_frame(0, frame8(8'hF0), Nb8, "b2b_f0");
`endif
    @(negedge sys_clk);
    valid8 = 1'b0;
`ifdef UART_TX_PARITY_EN
    check_frame(0, frame8(8'h0F, 1'b0), Nb8, "b2b_0f");
`else
    check_frame(0, frame8(8'h0F), Nb8, "b2b_0f");
`endif
    @(negedge sys_clk);
    n_tests++; if (idle8 !== 1'b1) begin n_fail++; $display("FAIL b2b idle after: got %b required 1", idle8); end
  endtask

  task automatic test_data7_stop2();
    valid7 = 1'b1;
    data7  = 7'h55;
    @(negedge sys_clk);
    valid7 = 1'b0;
    data7  = 7'h2A;
`ifdef UART_TX_PARITY_EN
    check_frame(1, frame7(7'h55, 1'b0), Nb7, "d7s2_55");
`else
    check_frame(1, frame7(7'h55), Nb7, "d7s2_55");
`endif
    @(negedge sys_clk);
    n_tests++; if (idle7 !== 1'b1) begin n_fail++; $display("FAIL d7s2 idle after: got %b required 1", idle7); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    valid8 = 1'b1; data8 = 8'hA5;
    valid_o = 1'b1; data_o = 8'hA5;
    @(negedge sys_clk);
    valid8 = 1'b0; valid_o = 1'b0;
    fork
      check_frame(0, frame8(8'hA5, 1'b0), Nb8, "parity_even_a5");
      check_frame(2, frame8(8'hA5, 1'b1), Nb8, "parity_odd_a5");
    join
    @(negedge sys_clk);
  endtask
`endif

  task automatic test_reset_mid_frame();
    int ok_seen, txd_low;
    valid8 = 1'b1;
    data8  = 8'h33;
    @(negedge sys_clk);
    valid8 = 1'b0;
    // Cycle 140 lies in data bit 3 (cycles 129..160); bit 3 of 8'h33 is 0.
    repeat (139) @(negedge sys_clk);
    n_tests++; if (txd8 !== 1'b0) begin n_fail++; $display("FAIL midreset pre txd: got %b required 0", txd8); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (txd8 !== 1'b1) begin n_fail++; $display("FAIL midreset txd: got %b required 1", txd8); end
    n_tests++; if (idle8 !== 1'b1) begin n_fail++; $display("FAIL midreset tx_idle: got %b required 1", idle8); end
    n_tests++; if (ok8 !== 1'b0) begin n_fail++; $display("FAIL midreset tx_bits_ok: got %b required 0", ok8); end
    @(negedge sys_clk);
    rst_n = 1'b1;
    ok_seen = 0;
    txd_low = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge sys_clk);
      if (ok8 !== 1'b0) ok_seen++;
      if (txd8 !== 1'b1) txd_low++;
    end
    n_tests++;
    if (ok_seen != 0 || txd_low != 0) begin
      n_fail++;
      $display("FAIL midreset aftermath: tx_bits_ok high %0d cycles, txd not 1 %0d cycles, required 0 and 0",
               ok_seen, txd_low);
    end
    valid8 = 1'b1;
    data8  = 8'h0F;
    @(negedge sys_clk);
    valid8 = 1'b0;
`ifdef UART_TX_PARITY_EN
    check_frame(0, frame8(8'h0F, 1'b0), Nb8, "post_reset_0f");
`else
    check_frame(0, frame8(8'h0F), Nb8, "post_reset_0f");
`endif
    @(negedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_data7_stop2();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
